// File: rtl/uart_transmitter.sv
// UART transmit path: one byte per valid/ready handshake, serialised as start, LSB-first data, stop.
// Optional parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 i_clock,
    input  logic                 i_resetL,
    input  logic                 i_valid,
    input  logic [DATA_BITS-1:0] i_data,
    output logic                 o_ready,
    output logic                 o_TX,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;
`endif

    // Even parity over the data bits, inverted for odd parity.
    function automatic logic parity_of(input logic [DATA_BITS-1:0] data);
        return (^data) ^ (PARITY_ODD != 0);
    endfunction

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic                 bit_end_s;
`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_d;
`endif

    assign bit_end_s = (cnt_q == CNT_LAST);

    // State and datapath registers; reset drives the line to mark immediately.
    always_ff @(posedge i_clock or negedge i_resetL) begin
        if (!i_resetL) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next-state, baud/bit counting and the registered line value.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (i_valid) begin
                    state_d = START;
                    shift_d = i_data;
                    idx_d   = '0;
                    tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
                    par_d   = parity_of(i_data);
`endif
                end else begin
                    tx_d = 1'b1;
                end
            end
            START: begin
                if (bit_end_s) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = par_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                        idx_d   = idx_q + IDX_W'(1);
                        tx_d    = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end_s) begin
                    state_d = STOP;
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            STOP: begin
                tx_d = 1'b1;
                if (bit_end_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                // Unused encodings recover to an idle, marking line.
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign o_TX    = tx_q;
    assign o_done  = done_q;
    assign o_ready = (state_q == IDLE);
    assign o_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter at CLKS_PER_BIT=4, DATA_BITS=8 (default build, no parity).
module tb_uart_transmitter;

    logic       clk = 1'b0;
    logic       i_resetL = 1'b1;
    logic       i_valid = 1'b0;
    logic [7:0] i_data = 8'h00;
    logic       o_ready, o_TX, o_busy, o_done;
    int         checks = 0;
    int         failures = 0;

    uart_transmitter #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_ODD(0)) dut (
        .i_clock (clk),
        .i_resetL(i_resetL),
        .i_valid (i_valid),
        .i_data  (i_data),
        .o_ready (o_ready),
        .o_TX    (o_TX),
        .o_busy  (o_busy),
        .o_done  (o_done)
    );

    always #5 clk = ~clk;

    // frame bit k = k-th transmitted bit: start, data LSB first, stop
    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
        bit         scramble;
        bit         poke;
    } vec_t;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Called just after a negedge; sends one frame and checks every cycle of it.
    task automatic run_frame(input logic [7:0] d, input logic [9:0] fr, input bit scramble, input bit poke);
        i_valid = 1'b1;
        i_data  = d;
        @(posedge clk);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            i_valid = poke && (c == 12);
            if (poke && (c == 12)) i_data = 8'hFF;
            else if (scramble)     i_data = 8'($urandom);
            else                   i_data = d;
            chk("tx_bit", o_TX, fr[c/4]);
            chk("ready_low", o_ready, 1'b0);
            chk("busy_high", o_busy, 1'b1);
            chk("done_low", o_done, 1'b0);
        end
        @(negedge clk);
        i_valid = 1'b0;
        chk("done_pulse", o_done, 1'b1);
        chk("ready_back", o_ready, 1'b1);
        chk("busy_back", o_busy, 1'b0);
        chk("tx_idle", o_TX, 1'b1);
        @(negedge clk);
        chk("done_one_cycle", o_done, 1'b0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("no_extra_frame_tx", o_TX, 1'b1);
            chk("no_extra_frame_busy", o_busy, 1'b0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[5];
        logic [9:0] f1, f2;
        logic       exp_tx;
        int         dones;

        vecs[0] = '{8'h55, 10'h2AA, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 10'h278, 1'b1, 1'b0};
        vecs[2] = '{8'hA3, 10'h346, 1'b0, 1'b1};
        vecs[3] = '{8'hFF, 10'h3FE, 1'b0, 1'b0};
        vecs[4] = '{8'h00, 10'h200, 1'b0, 1'b0};

        #1 i_resetL = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", o_TX, 1'b1);
        chk("rst_ready", o_ready, 1'b1);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_done", o_done, 1'b0);
        i_resetL = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 5; v++)
            run_frame(vecs[v].data, vecs[v].frame, vecs[v].scramble, vecs[v].poke);

        // Back-to-back: valid held through the first frame with the second byte.
        f1 = 10'h346;
        f2 = 10'h21E;
        dones = 0;
        i_valid = 1'b1;
        i_data  = 8'hA3;
        @(posedge clk);
        for (int c = 0; c < 91; c++) begin
            @(negedge clk);
            if (c == 0)  i_data  = 8'h0F;
            if (c == 41) i_valid = 1'b0;
            if (c < 40)       exp_tx = f1[c/4];
            else if (c == 40) exp_tx = 1'b1;
            else if (c < 81)  exp_tx = f2[(c-41)/4];
            else              exp_tx = 1'b1;
            chk("b2b_tx", o_TX, exp_tx);
            chk("b2b_done", o_done, (c == 40) || (c == 81));
            chk("b2b_ready", o_ready, (c == 40) || (c >= 81));
            if (o_done) dones++;
        end
        checks++;
        if (dones != 2) begin
            failures++;
            $display("FAIL b2b_done_count: got %0d expected 2", dones);
        end

        // Reset during data bit 3 of 0x00, then a clean frame.
        i_valid = 1'b1;
        i_data  = 8'h00;
        @(posedge clk);
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            i_valid = 1'b0;
            chk("pre_reset_tx", o_TX, 1'b0);
        end
        #2 i_resetL = 1'b0;
        #1;
        chk("async_rst_tx", o_TX, 1'b1);
        chk("async_rst_busy", o_busy, 1'b0);
        chk("async_rst_ready", o_ready, 1'b1);
        chk("async_rst_done", o_done, 1'b0);
        @(negedge clk);
        i_resetL = 1'b1;
        @(negedge clk);
        chk("post_rst_tx", o_TX, 1'b1);
        run_frame(8'h81, 10'h302, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
